// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: requester handshakes and I2C driver bus shared by the arbiter and its clients.
interface i2c_req_arbiter_if;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_gnt;
    logic        wr_done;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_gnt;
    logic        rd_done;
    logic [7:0]  rd_data;
    logic        i2c_exec;
    logic        i2c_rh_wl;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w;
    logic        i2c_done;
    logic [7:0]  i2c_data_r;
    logic        i2c_ack;
    logic        busy;
    logic        err;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, i2c_done, i2c_data_r, i2c_ack,
        output wr_gnt, wr_done, rd_gnt, rd_done, rd_data, i2c_exec, i2c_rh_wl, i2c_addr,
               i2c_data_w, busy, err
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, i2c_done, i2c_data_r, i2c_ack,
        input  wr_gnt, wr_done, rd_gnt, rd_done, rd_data, i2c_exec, i2c_rh_wl, i2c_addr,
               i2c_data_w, busy, err
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin arbiter serving one EEPROM write or read requester at a time on a single I2C driver.
// Optional watchdog on i2c_done enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter #(
    parameter int WR_WAIT_CYC = 250000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input logic              clk,
    input logic              rstn,
    i2c_req_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WR_GAP} state_t;

    localparam int CW = $clog2((WR_WAIT_CYC > TIMEOUT_CYC ? WR_WAIT_CYC : TIMEOUT_CYC) + 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(WR_WAIT_CYC - 1);
`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_rd;
    logic          pick_rd;

    assign pick_rd = bus.rd_req && (!bus.wr_req || !last_rd);

    // Transaction FSM; the write gap and the watchdog share cnt since they never overlap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            cnt            <= '0;
            last_rd        <= 1'b1;
            bus.wr_gnt     <= 1'b0;
            bus.rd_gnt     <= 1'b0;
            bus.wr_done    <= 1'b0;
            bus.rd_done    <= 1'b0;
            bus.err        <= 1'b0;
            bus.i2c_exec   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.i2c_rh_wl  <= 1'b0;
            bus.i2c_addr   <= '0;
            bus.i2c_data_w <= '0;
            bus.rd_data    <= '0;
        end else begin
            bus.wr_gnt   <= 1'b0;
            bus.rd_gnt   <= 1'b0;
            bus.wr_done  <= 1'b0;
            bus.rd_done  <= 1'b0;
            bus.err      <= 1'b0;
            bus.i2c_exec <= 1'b0;
            case (state)
                IDLE: if (bus.wr_req || bus.rd_req) begin
                    bus.i2c_rh_wl <= pick_rd;
                    bus.i2c_addr  <= pick_rd ? bus.rd_addr : bus.wr_addr;
                    if (!pick_rd) bus.i2c_data_w <= bus.wr_data;
                    bus.rd_gnt    <= pick_rd;
                    bus.wr_gnt    <= !pick_rd;
                    bus.i2c_exec  <= 1'b1;
                    bus.busy      <= 1'b1;
                    last_rd       <= pick_rd;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: if (bus.i2c_done) begin
                    bus.wr_done <= !bus.i2c_rh_wl;
                    bus.rd_done <= bus.i2c_rh_wl;
                    bus.err     <= bus.i2c_ack;
                    if (bus.i2c_rh_wl && !bus.i2c_ack) bus.rd_data <= bus.i2c_data_r;
                    if (!bus.i2c_rh_wl && !bus.i2c_ack) begin
                        cnt   <= '0;
                        state <= WR_GAP;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    bus.wr_done <= !bus.i2c_rh_wl;
                    bus.rd_done <= bus.i2c_rh_wl;
                    bus.err     <= 1'b1;
                    if (bus.i2c_rh_wl) bus.rd_data <= 8'hFF;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end else cnt <= cnt + CW'(1);
`endif
                WR_GAP: if (cnt == GAP_LAST) begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end else cnt <= cnt + CW'(1);
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: randomized requesters and I2C driver checked against a transaction-level model.
module tb_i2c_req_arbiter;
    localparam int W  = 20;
    localparam int TO = 100;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    i2c_req_arbiter_if bus();

    i2c_req_arbiter #(.WR_WAIT_CYC(W), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    bit         m_last_rd = 1'b1;
    logic [7:0] m_rd = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic raise(input bit wr, input bit rd, input bit fixed);
        if (wr && !bus.wr_req) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = fixed ? 16'h004D : 16'($urandom);
            bus.wr_data = fixed ? 8'h37 : 8'($urandom);
        end
        if (rd && !bus.rd_req) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = fixed ? 16'h004D : 16'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 32'({bus.busy, bus.wr_gnt, bus.rd_gnt, bus.wr_done, bus.rd_done,
                               bus.err, bus.i2c_exec, bus.i2c_rh_wl}), 0);
        chk({tag, "_addr"}, 32'(bus.i2c_addr), 0);
        chk({tag, "_data_w"}, 32'(bus.i2c_data_w), 0);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 0);
    endtask

    task automatic wait_gnt(output int t);
        t = 0;
        while (!(bus.wr_gnt || bus.rd_gnt) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("gnt_timeout", 32'(t >= 50), 0);
    endtask

    // One full transaction: arbitration, issue, driver response, and the gap that follows.
    task automatic txn(input bit both, input bit fixed, input bit last, input int order);
        bit         exp_rd, ack, a, b, stray;
        int         t, l, gap;
        logic [15:0] ea;
        logic [7:0]  ed, dr;
        if (!(bus.wr_gnt || bus.rd_gnt)) begin
            if (both) raise(1'b1, 1'b1, fixed);
            else begin
                a = 1'($urandom);
                b = 1'($urandom);
                if (!a && !b) a = 1'b1;
                raise(a, b, 1'b0);
            end
        end
        exp_rd = bus.rd_req && (!bus.wr_req || !m_last_rd);
        ea     = exp_rd ? bus.rd_addr : bus.wr_addr;
        ed     = bus.wr_data;
        wait_gnt(t);
        chk("gnt_rd", 32'(bus.rd_gnt), 32'(exp_rd));
        chk("gnt_wr", 32'(bus.wr_gnt), 32'(!exp_rd));
        if (order >= 0) chk("order_rd", 32'(bus.rd_gnt), 32'(order % 2));
        chk("exec", 32'(bus.i2c_exec), 1);
        chk("rh_wl", 32'(bus.i2c_rh_wl), 32'(exp_rd));
        chk("addr", 32'(bus.i2c_addr), 32'(ea));
        if (!exp_rd) chk("data_w", 32'(bus.i2c_data_w), 32'(ed));
        m_last_rd = exp_rd;
        if (exp_rd) bus.rd_req = 1'b0;
        else bus.wr_req = 1'b0;
        if (last) begin
            bus.wr_req = 1'b0;
            bus.rd_req = 1'b0;
        end
        l   = $urandom_range(0, 3);
        ack = fixed ? 1'b0 : ($urandom_range(0, 3) == 0);
        dr  = fixed ? 8'h37 : 8'($urandom);
        @(negedge clk);
        chk("exec_pulse", 32'(bus.i2c_exec), 0);
        chk("busy", 32'(bus.busy), 1);
        repeat (l) @(negedge clk);
        chk("addr_hold", 32'(bus.i2c_addr), 32'(ea));
        bus.i2c_done   = 1'b1;
        bus.i2c_ack    = ack;
        bus.i2c_data_r = dr;
        @(negedge clk);
        bus.i2c_done = 1'b0;
        bus.i2c_ack  = 1'b0;
        if (exp_rd && !ack) m_rd = dr;
        chk("wr_done", 32'(bus.wr_done), 32'(!exp_rd));
        chk("rd_done", 32'(bus.rd_done), 32'(exp_rd));
        chk("err", 32'(bus.err), 32'(ack));
        chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
        gap   = 0;
        stray = 1'b0;
        while (bus.busy && !(bus.wr_gnt || bus.rd_gnt) && gap < W + 50) begin
            if (gap > 0 && (bus.wr_done || bus.rd_done || bus.err)) stray = 1'b1;
            bus.i2c_done = (gap == 3);
            bus.i2c_ack  = 1'($urandom);
            @(negedge clk);
            gap++;
        end
        bus.i2c_done = 1'b0;
        bus.i2c_ack  = 1'b0;
        chk("gap", 32'(gap), (!exp_rd && !ack) ? 32'(W) : 32'(0));
        chk("stray_done", 32'(stray), 0);
    endtask

    initial begin
        int t;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        bus.i2c_done = 1'b0; bus.i2c_ack = 1'b0; bus.i2c_data_r = '0;
        raise(1'b1, 1'b1, 1'b1);
        #2 rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) txn(1'b1, 1'b1, i == 3, i);
        for (int i = 0; i < 30; i++) txn(1'b0, 1'b0, i == 29, -1);

        raise(1'b0, 1'b1, 1'b0);
        wait_gnt(t);
        chk("to_gnt_rd", 32'(bus.rd_gnt), 1);
        m_last_rd  = 1'b1;
        bus.rd_req = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        t = 0;
        while (!bus.rd_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        // grant cycle is ISSUE, then TO cycles of WAIT_DONE before the pulse shows
        chk("to_cycles", 32'(t), 32'(TO + 1));
        chk("to_err", 32'(bus.err), 1);
        chk("to_rd_data", 32'(bus.rd_data), 32'h0000_00FF);
        raise(1'b0, 1'b1, 1'b0);
        wait_gnt(t);
        bus.rd_req = 1'b0;
        repeat (5) @(negedge clk);
`else
        repeat (300) @(negedge clk);
        chk("no_to_busy", 32'(bus.busy), 1);
        chk("no_to_done", 32'(bus.rd_done | bus.err), 0);
`endif
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge clk);
        chk("reset_hold_done", 32'({bus.wr_done, bus.rd_done, bus.err}), 0);
        rstn      = 1'b1;
        m_last_rd = 1'b1;
        m_rd      = 8'h00;
        @(negedge clk);
        chk("post_reset_idle", 32'({bus.busy, bus.rd_done, bus.wr_done}), 0);
        for (int i = 0; i < 6; i++) txn(1'b0, 1'b0, i == 5, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 SHALL have parameter WR_WAIT_CYC, default 250000, giving the EEPROM write-cycle gap in clk cycles (5 ms at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000000, giving the i2c_done watchdog limit in clk cycles.
REQ-003 SHALL have port clk  in  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports wr_req in 1 (level request), wr_addr in 16, wr_data in 8, wr_gnt out 1 (accept pulse) and wr_done out 1 (completion pulse).
REQ-006 SHALL have ports rd_req in 1, rd_addr in 16, rd_gnt out 1, rd_done out 1 and rd_data out 8 (read result).
REQ-007 SHALL have ports i2c_exec out 1 (start pulse to driver), i2c_rh_wl out 1 (1=read, 0=write), i2c_addr out 16 and i2c_data_w out 8.
REQ-008 SHALL have ports i2c_done in 1 (driver completion pulse), i2c_data_r in 8 and i2c_ack in 1 (1=NACK seen, valid with i2c_done).
REQ-009 SHALL have ports busy out 1 (state not IDLE) and err out 1 (error pulse).

Function
REQ-010 SHALL implement the FSM states IDLE, ISSUE, WAIT_DONE and WR_GAP.
REQ-011 In IDLE with any request asserted, SHALL on the next edge latch the winner's addr/data (and rd/wr type), pulse its gnt for 1 cycle, and enter ISSUE.
REQ-012 Arbitration SHALL be round-robin: when both requests are asserted, grant the type not served last; a single requester always wins.
REQ-013 ISSUE SHALL assert i2c_exec for exactly 1 cycle, hold i2c_addr/i2c_data_w/i2c_rh_wl stable from ISSUE until leaving WAIT_DONE, then enter WAIT_DONE.
REQ-014 In WAIT_DONE on i2c_done with i2c_ack=0: a write SHALL pulse wr_done and enter WR_GAP; a read SHALL latch i2c_data_r into rd_data, pulse rd_done and return to IDLE.
REQ-015 On i2c_done with i2c_ack=1, SHALL pulse err and the owner's done together, leave rd_data unchanged, and return to IDLE without entering WR_GAP.
REQ-016 WR_GAP SHALL count 0..WR_WAIT_CYC-1 and then return to IDLE; no grant SHALL be issued during WR_GAP.
REQ-017 Requesters hold req until gnt; a req still high in the cycle after gnt SHALL be treated as a new request.
REQ-018 i2c_done outside WAIT_DONE SHALL be ignored.
REQ-019 The minimum gap from a gnt to the next gnt for back-to-back reads SHALL be 3 cycles plus the driver latency.

Reset
REQ-020 On rstn low, SHALL enter IDLE and clear all counters; all gnt/done/err/i2c_exec/busy outputs, i2c_rh_wl, i2c_addr, i2c_data_w and rd_data SHALL be 0; last-served SHALL be read, so a write wins the first tie.
REQ-021 Reset mid-transaction SHALL abandon the transaction and issue no done pulse.

Configuration
REQ-022 With I2C_ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT_DONE; on reaching TIMEOUT_CYC-1 without i2c_done, SHALL pulse err and the owner's done, set rd_data=8'hFF for reads, and return to IDLE.
REQ-023 Without I2C_ARB_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely and no watchdog logic SHALL exist.

Verification
REQ-024 wr_req with addr 16'h004D, data 8'h37 -> wr_gnt pulse, i2c_exec once with rh_wl=0, addr 004D, data 37; done -> wr_done, then WR_GAP of exactly WR_WAIT_CYC cycles before busy=0.
REQ-025 rd_req with addr 16'h004D, driver returns 8'h37 -> rd_done with rd_data=8'h37 and no WR_GAP.
REQ-026 wr_req and rd_req both held from reset -> grant order wr, rd, wr, rd; no rd_gnt during WR_GAP.
REQ-027 Read completes with i2c_ack=1 -> err and rd_done in the same cycle, rd_data keeps its old value, next grant without a gap.
REQ-028 With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYC=100, no i2c_done -> err plus rd_done 100 cycles into WAIT_DONE, rd_data=8'hFF; without the macro, busy stays 1.
REQ-029 rstn asserted low during WAIT_DONE -> all outputs 0 immediately, no done pulse; a following request is served normally.
